// File: rtl/alu_op_sequencer_if.sv
// Operand-fetch bus and result handshake between the sequencer and its neighbours.
// The slave side is the sequencer; the master side is whoever feeds operands and consumes results.
interface alu_op_sequencer_if;
   logic [15:0] bus_in;
   logic        bus_valid;
   logic        bus_ready;
   logic [15:0] result;
   logic [3:0]  flags;
   logic        res_valid;
   logic        res_ready;

   modport master (
      output bus_in, bus_valid, res_ready,
      input  bus_ready, result, flags, res_valid
   );

   modport slave (
      input  bus_in, bus_valid, res_ready,
      output bus_ready, result, flags, res_valid
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetches two operands, drives the 16-bit add/sub math unit, and captures its result and
// the persistent {C,V,N,Z} status flags, then hands the result downstream.
module alu_op_sequencer #(
   parameter int FETCH_TIMEOUT = 0,
   parameter int TO_W          = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_sub,
   alu_op_sequencer_if.slave bif,
   output logic [15:0]       alu_a,
   output logic [15:0]       alu_b,
   output logic              alu_sub,
   input  logic [15:0]       alu_sum,
   input  logic              alu_cout,
   input  logic              alu_ovf,
   input  logic              alu_no,
   input  logic              alu_zo,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_A = 3'd1,
      S_FETCH_B = 3'd2,
      S_EXEC    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam bit              TO_EN   = (FETCH_TIMEOUT != 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);
   localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);
   localparam logic [TO_W-1:0] CNT_ZERO = {TO_W{1'b0}};

   state_t          state_q, state_d;
   logic [15:0]     alu_a_q, alu_a_d;
   logic [15:0]     alu_b_q, alu_b_d;
   logic            alu_sub_q, alu_sub_d;
   logic [15:0]     result_q, result_d;
   logic [3:0]      flags_q, flags_d;
   logic            err_q, err_d;
   logic            bus_ready_q, bus_ready_d;
   logic            res_valid_q, res_valid_d;
   logic            busy_q, busy_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            expired_s;

   // The last permitted idle fetch cycle has been reached (never true when the timeout is disabled).
   assign expired_s = TO_EN && (cnt_q == TO_LAST);

   // Next-state, datapath capture and registered-output decode.
   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sub_d = alu_sub_q;
      result_d  = result_q;
      flags_d   = flags_q;
      cnt_d     = cnt_q;
      err_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH_A;
               alu_sub_d = op_sub;
               cnt_d     = CNT_ZERO;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH_A: begin
            // A handshake takes priority over a timeout expiring in the same cycle.
            if (bif.bus_valid) begin
               alu_a_d = bif.bus_in;
               state_d = S_FETCH_B;
               cnt_d   = CNT_ZERO;
            end else if (expired_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = TO_EN ? (cnt_q + CNT_ONE) : CNT_ZERO;
            end
         end
         S_FETCH_B: begin
            if (bif.bus_valid) begin
               alu_b_d = bif.bus_in;
               state_d = S_EXEC;
               cnt_d   = CNT_ZERO;
            end else if (expired_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = TO_EN ? (cnt_q + CNT_ONE) : CNT_ZERO;
            end
         end
         S_EXEC: begin
            result_d = alu_sum;
            flags_d  = {alu_cout, alu_ovf, alu_no, alu_zo};
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (bif.res_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Decoded from the next state so the registered outputs line up with state_q.
      bus_ready_d = (state_d == S_FETCH_A) || (state_d == S_FETCH_B);
      res_valid_d = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         alu_a_q     <= 16'h0000;
         alu_b_q     <= 16'h0000;
         alu_sub_q   <= 1'b0;
         result_q    <= 16'h0000;
         flags_q     <= 4'b0000;
         err_q       <= 1'b0;
         bus_ready_q <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= CNT_ZERO;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sub_q   <= alu_sub_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
         bus_ready_q <= bus_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_sub       = alu_sub_q;
   assign bif.result    = result_q;
   assign bif.flags     = flags_q;
   assign bif.bus_ready = bus_ready_q;
   assign bif.res_valid = res_valid_q;
   assign busy          = busy_q;
   assign err           = err_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Sequencing stage directly upstream of the 16-bit add/subtract math unit. It fetches operands A and B from the data bus over a valid/ready handshake, drives them and the subtract control into the math unit, and captures the result and the four status flags (C, V, N, Z) into registers. It then presents the result downstream over a valid/ready handshake. The flag register is persistent and also serves as the CPU status flags.

Parameters:
FETCH_TIMEOUT, 0, cycles allowed in each fetch state waiting for bus_valid; 0 disables the timeout.
TO_W, 8, width of the timeout counter; FETCH_TIMEOUT must be < 2^TO_W.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request an operation; sampled only in IDLE
op_sub  input  1  1 = A-B, 0 = A+B; captured with start
bus_in  input  16  operand data from bus
bus_valid  input  1  bus_in holds a valid operand
bus_ready  output  1  sequencer accepts an operand this cycle
alu_a  output  16  operand A to math unit (registered)
alu_b  output  16  operand B to math unit (registered)
alu_sub  output  1  subtract control to math unit (registered)
alu_sum  input  16  math unit sum
alu_cout  input  1  math unit carry out
alu_ovf  input  1  math unit overflow
alu_no  input  1  math unit negative flag
alu_zo  input  1  math unit zero flag
result  output  16  captured result
flags  output  4  {C,V,N,Z}, persistent
res_valid  output  1  result available
res_ready  input  1  downstream accepts result
busy  output  1  state != IDLE
err  output  1  one-cycle pulse on fetch timeout

Behaviour:
- Single clock domain; clk rising edge. rst_n asynchronous active-low: state forced to IDLE. All of the following go to 0: alu_a, alu_b, alu_sub, result, flags, res_valid, err, bus_ready, busy, and the timeout counter.
- States: IDLE, FETCH_A, FETCH_B, EXEC, DONE.
- IDLE: start=1 → FETCH_A, alu_sub <= op_sub. start=0 → stay.
- FETCH_A: bus_ready=1. bus_valid=1 → alu_a <= bus_in, go to FETCH_B.
- FETCH_B: bus_ready=1. bus_valid=1 → alu_b <= bus_in, go to EXEC.
- EXEC: single cycle; math unit inputs are stable. At the edge: result <= alu_sum, flags <= {alu_cout, alu_ovf, alu_no, alu_zo}, go to DONE.
- DONE: res_valid=1. result and flags held stable. res_ready=1 → IDLE on that edge; otherwise stay.
- bus_ready is decoded from state, high only in FETCH_A/FETCH_B. res_valid is high only in DONE. busy is high in every state except IDLE.
- Minimum latency with bus_valid tied high: start sampled at edge 0 → A at edge 1 → B at edge 2 → result/flags at edge 3 → res_valid high from edge 3 until res_ready.
- A new start is accepted in the cycle after the DONE→IDLE edge. start is ignored in every non-IDLE state; no queuing.
- op_sub changes after start are ignored until the next IDLE start.
- Timeout (FETCH_TIMEOUT>0):
  - Counter clears on entry to each fetch state and increments each cycle without a handshake.
  - When it reaches FETCH_TIMEOUT without a handshake: go to IDLE, err=1 for exactly one cycle, result/flags unchanged.
  - A handshake in the same cycle the count expires wins; no error.
- flags change only on EXEC→DONE edges; they survive the error abort and the return to IDLE.
- alu_a/alu_b retain their last values outside fetch states.
- Reset asserted mid-operation (any state) aborts immediately. No res_valid or err is produced for the aborted operation.
- Arithmetic is done entirely by the math unit: 16-bit wrap, C = raw carry out (subtract: C=1 means no borrow).

Test Plan:
- Add with overflow: start, op_sub=0, bus 0x7FFF then 0x0001, valid always high, res_ready=1 → res_valid at edge 3, result=0x8000, flags=4'b0110 (C0 V1 N1 Z0).
- Subtract to zero: 0x0005 − 0x0005 → result=0x0000, flags=4'b1001. Then 0x0000 − 0x0001 → result=0xFFFF, flags=4'b0010.
- Add wrap: 0xFFFF + 0x0001 → result=0x0000, flags=4'b1001. Hold res_ready=0 for 5 cycles → res_valid, result and flags stable; start pulses during DONE are ignored.
- Bus stalls: bus_valid low 3 cycles in FETCH_A and 2 in FETCH_B with FETCH_TIMEOUT=0 → no capture during stalls, correct sum 0x1234+0x0F0F=0x2143, flags=4'b0000.
- Timeout: FETCH_TIMEOUT=4, bus_valid never asserted in FETCH_B → err pulses for one cycle, state returns to IDLE, flags keep the prior value. Handshake exactly at expiry → no err.
- Reset: assert rst_n=0 in EXEC → all outputs 0 immediately (asynchronous). Release and run 0x0002+0x0003 → 0x0005, flags=4'b0000.
